sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one SRAM instance (independent registered read port, byte-lane-free word-masked write port, fixed read latency) between NREQ read requesters and NREQ write requesters. Reads and writes are arbitrated independently, each with its own round-robin pointer. The block holds a tag pipeline that matches the SRAM read latency and routes each returned `readData` to the requester that issued the read. It also resolves same-cycle read/write address collisions. It sits between the cache/fetch clients and the SRAM macro and drives all SRAM ports directly.

## Interface
- `WIDTH`, 512, SRAM line width in bits.
- `LOG_DEPTH`, 7, SRAM address width.
- `WORDSIZE`, 64, write-mask granularity. `WIDTH/WORDSIZE` is the mask width.
- `NREQ`, 2, number of read requesters and number of write requesters (≥2).
- `READ_LAT`, 1, cycles from read grant to data on `readData`. Must equal the SRAM `delay+1`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rd_valid` in NREQ: per-requester read request.
- `rd_addr` in NREQ×LOG_DEPTH: per-requester read address.
- `rd_ready` out NREQ: read grant. One-hot or zero.
- `rsp_valid` out NREQ: one-hot read-return strobe.
- `rsp_data` out WIDTH: returned line, broadcast to all requesters.
- `wr_valid` in NREQ: per-requester write request.
- `wr_addr` in NREQ×LOG_DEPTH: write address.
- `wr_data` in NREQ×WIDTH: write data.
- `wr_strb` in NREQ×(WIDTH/WORDSIZE): word enables.
- `wr_ready` out NREQ: write grant. One-hot or zero.
- `sram_readAddr` out LOG_DEPTH, `sram_readData` in WIDTH: SRAM read port.
- `sram_writeAddr` out LOG_DEPTH, `sram_writeData` out WIDTH, `sram_writeEnable` out WIDTH/WORDSIZE: SRAM write port.

## Operation
- A transfer occurs on a requester's channel in a cycle where `valid && ready` are both high. Grants are combinational from `valid` and the pointer.
- Requesters hold `valid`, address, data and strobe stable until granted. They must not drop a request before it is granted.
- Write arbitration: the winner is the first requester with `wr_valid`=1, scanning from `wr_ptr` upward modulo NREQ. The winner's addr, data and strb drive the SRAM. `sram_writeEnable` = winner's `wr_strb`, or 0 if there is no winner.
- On a write grant to requester i, `wr_ptr` ← (i+1) mod NREQ. A grant with all-zero `wr_strb` is still a grant and performs no memory change.
- Read arbitration uses the same scheme with `rd_ptr`. The winner's address drives `sram_readAddr`. If there is no winner, `sram_readAddr` holds its last value.
- Collision rule: if the read winner's address equals the granted write address in the same cycle, the read is not granted. `rd_ready` is all 0 and `rd_ptr` is unchanged. The read is retried next cycle and then sees the new data.
- The write is never stalled.
- Tag pipe: READ_LAT stages of {valid, id}. Stage 0 loads {read granted, winner id}, and each stage shifts one per cycle.
- `rsp_valid` = one-hot(id) of the last stage when that stage is valid.
- `rsp_data` = `sram_readData`, combinational pass-through.
- There is no response backpressure. Requesters always accept `rsp_valid`.
- Responses return in grant order. One read and one write can be granted per cycle. Read throughput is one read per cycle.

## Timing
- Read granted in cycle c → `rsp_valid` and `rsp_data` valid in cycle c+READ_LAT.
- Write granted in cycle c → data visible to a read granted in cycle c+1 or later.
- While `reset`=1:
  - all `rd_ready`, `wr_ready` and `rsp_valid` outputs are 0;
  - `sram_writeEnable` = 0.
- At the clock edge where `reset` is sampled high:
  - `rd_ptr` and `wr_ptr` are set to 0;
  - all tag-pipe valids are cleared;
  - `sram_readAddr` is set to 0.
- Reads in flight when reset is asserted are dropped and never produce `rsp_valid`.
- The first grant is possible in the cycle after reset deasserts.
- Pointer wrap: after a grant to requester NREQ-1 the pointer becomes 0.

## Structure
- Package `sram_ctrl_pkg` contains:
  - the `req_id_t` typedef, sized `$clog2(NREQ)`;
  - the `onehot` function, id → NREQ mask;
  - the tag-pipe entry struct {valid, id}.
- One sub-module, `rr_arbiter` (parameter NREQ; inputs `req`, `ptr`, `en`; outputs `grant`, `gnt_id`, `any`), is instantiated twice: once for reads, once for writes.
- The read instance's `en` input is driven low on a collision.
- The SRAM is instantiated by the parent. This block only drives its ports.

## Test plan
- **Reset:** hold `reset` 3 cycles with all valids=1 → all ready, rsp_valid and writeEnable=0. The first post-reset grant goes to requester 0.
- **Read fairness:** NREQ=2, both `rd_valid` high for 6 cycles → grants alternate 0,1,0,1,0,1. Each `rsp_valid` one-hot follows its grant by READ_LAT with matching data.
- **Collision:** in the same cycle, write req 0 to addr 5 with data 0xAA…, strb all-ones, and read req 1 from addr 5 → `rd_ready`=0 that cycle. The read is granted next cycle and returns 0xAA….
- **Partial write:** write addr 3 full 0x11…, then addr 3 `wr_strb`=0x01 with data 0x22… → the read returns word0=0x22…22 and words1–7=0x11….
- **Zero strobe:** a write with `wr_strb`=0 is granted, `wr_ptr` advances, and a subsequent read shows the memory is unchanged.
- **Reset mid-flight:** a read granted in cycle c, with `reset` asserted at c+READ_LAT-1 (READ_LAT=3 build) → no `rsp_valid` from that read ever appears.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// sram_ctrl_pkg: shared types for the SRAM port arbiter.
// Holds requester id type, tag-pipe entry and one-hot/pointer helpers.
package sram_ctrl_pkg;

    localparam int NREQ = 2;
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    function automatic logic [NREQ-1:0] onehot(input req_id_t id);
        onehot     = '0;
        onehot[id] = 1'b1;
    endfunction

    // Round-robin pointer moves just past the last winner.
    function automatic req_id_t next_ptr(input req_id_t id);
        if (int'(id) == NREQ - 1)
            next_ptr = '0;
        else
            next_ptr = id + 1'b1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester-side read/write/response bundle.
// master = requesters (drive valid/addr/data/strb), slave = arbiter.
interface sram_port_arbiter_if #(
    parameter int WIDTH     = 512,
    parameter int LOG_DEPTH = 7,
    parameter int WORDSIZE  = 64,
    parameter int NREQ      = 2
);
    localparam int NW = WIDTH / WORDSIZE;

    logic [NREQ-1:0]                 rd_valid;
    logic [NREQ-1:0][LOG_DEPTH-1:0]  rd_addr;
    logic [NREQ-1:0]                 rd_ready;
    logic [NREQ-1:0]                 rsp_valid;
    logic [WIDTH-1:0]                rsp_data;
    logic [NREQ-1:0]                 wr_valid;
    logic [NREQ-1:0][LOG_DEPTH-1:0]  wr_addr;
    logic [NREQ-1:0][WIDTH-1:0]      wr_data;
    logic [NREQ-1:0][NW-1:0]         wr_strb;
    logic [NREQ-1:0]                 wr_ready;

    modport master (
        output rd_valid, rd_addr,
        output wr_valid, wr_addr, wr_data, wr_strb,
        input  rd_ready, rsp_valid, rsp_data, wr_ready
    );

    modport slave (
        input  rd_valid, rd_addr,
        input  wr_valid, wr_addr, wr_data, wr_strb,
        output rd_ready, rsp_valid, rsp_data, wr_ready
    );

endinterface

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of first req at or above ptr (mod NREQ).
// Ports: req/ptr/en in; grant (one-hot), gnt_id, any out. gnt_id ignores en.
module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NREQ = sram_ctrl_pkg::NREQ
) (
    input  logic [NREQ-1:0] req,
    input  req_id_t         ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output req_id_t         gnt_id,
    output logic            any
);

    logic w_found;
    int   w_idx;

    always_comb begin
        w_found = 1'b0;
        gnt_id  = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[req_id_t'(w_idx)]) begin
                w_found = 1'b1;
                gnt_id  = req_id_t'(w_idx);
            end
        end
    end

    assign any   = en && w_found;
    assign grant = any ? onehot(gnt_id) : '0;

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM between NREQ readers and NREQ writers.
// Ports: clk, reset, bus (slave), sram_read*/sram_write* to the macro.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH     = 512,
    parameter int LOG_DEPTH = 7,
    parameter int WORDSIZE  = 64,
    parameter int NREQ      = sram_ctrl_pkg::NREQ,
    parameter int READ_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    sram_port_arbiter_if.slave        bus,
    output logic [LOG_DEPTH-1:0]      sram_readAddr,
    input  logic [WIDTH-1:0]          sram_readData,
    output logic [LOG_DEPTH-1:0]      sram_writeAddr,
    output logic [WIDTH-1:0]          sram_writeData,
    output logic [WIDTH/WORDSIZE-1:0] sram_writeEnable
);

    logic [NREQ-1:0]      w_rd_grant;
    logic [NREQ-1:0]      w_wr_grant;
    req_id_t              w_rd_id;
    req_id_t              w_wr_id;
    logic                 w_rd_any;
    logic                 w_wr_any;
    logic                 w_collide;

    req_id_t              r_rd_ptr;
    req_id_t              r_wr_ptr;
    logic [LOG_DEPTH-1:0] r_rd_addr;
    tag_t                 r_tag [READ_LAT];

    rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
        .req    (bus.wr_valid),
        .ptr    (r_wr_ptr),
        .en     (!reset),
        .grant  (w_wr_grant),
        .gnt_id (w_wr_id),
        .any    (w_wr_any)
    );

    // A read to the address being written this cycle would see stale data
    // from the macro, so it waits one cycle.
    assign w_collide = w_wr_any &&
                       (bus.rd_addr[w_rd_id] == bus.wr_addr[w_wr_id]);

    rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
        .req    (bus.rd_valid),
        .ptr    (r_rd_ptr),
        .en     (!reset && !w_collide),
        .grant  (w_rd_grant),
        .gnt_id (w_rd_id),
        .any    (w_rd_any)
    );

    assign bus.rd_ready = w_rd_grant;
    assign bus.wr_ready = w_wr_grant;

    assign sram_writeAddr   = bus.wr_addr[w_wr_id];
    assign sram_writeData   = bus.wr_data[w_wr_id];
    assign sram_writeEnable = w_wr_any ? bus.wr_strb[w_wr_id] : '0;

    assign sram_readAddr = w_rd_any ? bus.rd_addr[w_rd_id] : r_rd_addr;

    assign bus.rsp_data  = sram_readData;
    assign bus.rsp_valid = (!reset && r_tag[READ_LAT-1].valid)
                         ? onehot(r_tag[READ_LAT-1].id) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rd_addr <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_tag[i].valid <= 1'b0;
                r_tag[i].id    <= '0;
            end
        end else begin
            if (w_rd_any) begin
                r_rd_ptr  <= next_ptr(w_rd_id);
                r_rd_addr <= bus.rd_addr[w_rd_id];
            end
            if (w_wr_any)
                r_wr_ptr <= next_ptr(w_wr_id);
            r_tag[0].valid <= w_rd_any;
            r_tag[0].id    <= w_rd_id;
            for (int i = 1; i < READ_LAT; i++)
                r_tag[i] <= r_tag[i-1];
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed + random checks against a queue model.
// Includes a behavioural SRAM with READ_LAT-cycle registered read.
module tb_sram_port_arbiter;

    localparam int WIDTH    = 512;
    localparam int LD       = 7;
    localparam int WS       = 64;
    localparam int NW       = WIDTH / WS;
    localparam int NREQ     = 2;
    localparam int READ_LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [LD-1:0]    sram_readAddr;
    logic [WIDTH-1:0] sram_readData;
    logic [LD-1:0]    sram_writeAddr;
    logic [WIDTH-1:0] sram_writeData;
    logic [NW-1:0]    sram_writeEnable;

    sram_port_arbiter_if #(
        .WIDTH(WIDTH), .LOG_DEPTH(LD), .WORDSIZE(WS), .NREQ(NREQ)
    ) bus ();

    sram_port_arbiter #(
        .WIDTH(WIDTH), .LOG_DEPTH(LD), .WORDSIZE(WS),
        .NREQ(NREQ), .READ_LAT(READ_LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .sram_readAddr    (sram_readAddr),
        .sram_readData    (sram_readData),
        .sram_writeAddr   (sram_writeAddr),
        .sram_writeData   (sram_writeData),
        .sram_writeEnable (sram_writeEnable)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] sram_mem [1<<LD];
    logic [WIDTH-1:0] rpipe [READ_LAT];

    always @(posedge clk) begin
        rpipe[0] <= sram_mem[sram_readAddr];
        for (int i = 1; i < READ_LAT; i++)
            rpipe[i] <= rpipe[i-1];
        for (int w = 0; w < NW; w++)
            if (sram_writeEnable[w])
                sram_mem[sram_writeAddr][w*WS +: WS] <= sram_writeData[w*WS +: WS];
    end

    assign sram_readData = rpipe[READ_LAT-1];

    typedef struct {
        int               id;
        int               due;
        logic [WIDTH-1:0] data;
    } rsp_t;

    logic [WIDTH-1:0] ref_mem [1<<LD];
    rsp_t             q [$];
    int               rptr = 0;
    int               wptr = 0;
    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;

    logic [NREQ-1:0]  g_rd, g_wr;
    logic [NREQ-1:0]  obs_rd, obs_wr, obs_rsp;
    logic [NW-1:0]    obs_we;
    logic [WIDTH-1:0] last_rsp;

    task automatic chk(input string tag,
                       input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_line();
        logic [WIDTH-1:0] r;
        for (int j = 0; j < WIDTH/32; j++)
            r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic step();
        int ew, er, i;
        logic [NREQ-1:0] erd, ewr, ersp;
        logic [NW-1:0]   ewe;
        #1;
        ew = -1;
        er = -1;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (wptr + k) % NREQ;
                if (ew < 0 && bus.wr_valid[i]) ew = i;
            end
            for (int k = 0; k < NREQ; k++) begin
                i = (rptr + k) % NREQ;
                if (er < 0 && bus.rd_valid[i]) er = i;
            end
            if (er >= 0 && ew >= 0 && bus.rd_addr[er] == bus.wr_addr[ew])
                er = -1;
        end
        erd = '0;
        ewr = '0;
        ewe = '0;
        if (er >= 0) erd[er] = 1'b1;
        if (ew >= 0) begin
            ewr[ew] = 1'b1;
            ewe = bus.wr_strb[ew];
        end
        obs_rd  = bus.rd_ready;
        obs_wr  = bus.wr_ready;
        obs_we  = sram_writeEnable;
        obs_rsp = bus.rsp_valid;
        if (obs_rsp != '0) last_rsp = bus.rsp_data;
        chk("rd_ready", obs_rd, erd);
        chk("wr_ready", obs_wr, ewr);
        chk("wen", obs_we, ewe);
        if (er >= 0) chk("raddr", sram_readAddr, bus.rd_addr[er]);
        if (ew >= 0) chk("waddr", sram_writeAddr, bus.wr_addr[ew]);
        ersp = '0;
        if (!reset && q.size() > 0 && q[0].due == cyc) begin
            ersp[q[0].id] = 1'b1;
            chk("rsp_data", bus.rsp_data, q[0].data);
            void'(q.pop_front());
        end
        chk("rsp_valid", obs_rsp, ersp);
        g_rd = erd;
        g_wr = ewr;
        @(posedge clk);
        if (reset) begin
            rptr = 0;
            wptr = 0;
            q.delete();
        end else begin
            if (er >= 0) begin
                q.push_back('{er, cyc + READ_LAT, ref_mem[bus.rd_addr[er]]});
                rptr = (er + 1) % NREQ;
            end
            if (ew >= 0) begin
                for (int w = 0; w < NW; w++)
                    if (bus.wr_strb[ew][w])
                        ref_mem[bus.wr_addr[ew]][w*WS +: WS] =
                            bus.wr_data[ew][w*WS +: WS];
                wptr = (ew + 1) % NREQ;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rd_valid = '0;
        bus.wr_valid = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    logic [WIDTH-1:0] part_line;
    int               cnt;

    initial begin
        for (int a = 0; a < (1<<LD); a++) begin
            sram_mem[a] = '0;
            ref_mem[a]  = '0;
        end
        for (int i = 0; i < READ_LAT; i++) rpipe[i] = '0;
        last_rsp = '0;

        // reset with everything requesting
        bus.rd_valid = '1;
        bus.rd_addr[0] = 7'd20;
        bus.rd_addr[1] = 7'd21;
        bus.wr_valid = '1;
        bus.wr_addr[0] = 7'd30;
        bus.wr_addr[1] = 7'd31;
        bus.wr_data[0] = rand_line();
        bus.wr_data[1] = rand_line();
        bus.wr_strb[0] = '1;
        bus.wr_strb[1] = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_rd_ready", obs_rd, '0);
            chk("rst_wr_ready", obs_wr, '0);
            chk("rst_wen", obs_we, '0);
            chk("rst_rsp", obs_rsp, '0);
        end
        reset = 1'b0;

        // read fairness
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fair", obs_rd, (k % 2 == 0) ? 2'b01 : 2'b10);
            for (int i = 0; i < NREQ; i++) begin
                if (g_rd[i]) bus.rd_addr[i] = 7'($urandom_range(20, 29));
                if (g_wr[i]) bus.wr_valid[i] = 1'b0;
            end
        end
        idle(READ_LAT + 1);

        // collision
        bus.wr_valid[0] = 1'b1;
        bus.wr_addr[0]  = 7'd5;
        bus.wr_data[0]  = {64{8'hAA}};
        bus.wr_strb[0]  = '1;
        bus.rd_valid[1] = 1'b1;
        bus.rd_addr[1]  = 7'd5;
        step();
        chk("coll_rd_ready", obs_rd, '0);
        chk("coll_wr_ready", obs_wr, 2'b01);
        bus.wr_valid = '0;
        step();
        chk("coll_retry", obs_rd, 2'b10);
        idle(READ_LAT + 1);
        chk("coll_data", last_rsp, {64{8'hAA}});

        // partial write
        bus.wr_valid[0] = 1'b1;
        bus.wr_addr[0]  = 7'd3;
        bus.wr_data[0]  = {64{8'h11}};
        bus.wr_strb[0]  = '1;
        step();
        bus.wr_data[0]  = {64{8'h22}};
        bus.wr_strb[0]  = 8'h01;
        step();
        bus.wr_valid = '0;
        bus.rd_valid[0] = 1'b1;
        bus.rd_addr[0]  = 7'd3;
        step();
        idle(READ_LAT + 1);
        part_line = {{7{64'h1111111111111111}}, 64'h2222222222222222};
        chk("partial", last_rsp, part_line);

        // zero strobe: granted, pointer moves, memory unchanged
        bus.wr_valid    = 2'b11;
        bus.wr_addr[0]  = 7'd9;
        bus.wr_data[0]  = rand_line();
        bus.wr_strb[0]  = '1;
        bus.wr_addr[1]  = 7'd3;
        bus.wr_data[1]  = '1;
        bus.wr_strb[1]  = '0;
        step();
        chk("zs_grant", obs_wr, 2'b10);
        chk("zs_wen", obs_we, '0);
        step();
        chk("zs_ptr", obs_wr, 2'b01);
        bus.wr_valid[0] = 1'b0;
        step();
        chk("zs_again", obs_wr, 2'b10);
        bus.wr_valid = '0;
        bus.rd_valid[1] = 1'b1;
        bus.rd_addr[1]  = 7'd3;
        step();
        idle(READ_LAT + 1);
        chk("zs_data", last_rsp, part_line);

        // reset while a read is in flight
        bus.rd_valid[0] = 1'b1;
        bus.rd_addr[0]  = 7'd3;
        step();
        chk("mf_grant", obs_rd, 2'b01);
        bus.rd_valid = '0;
        step();
        reset = 1'b1;
        cnt = 0;
        step();
        if (obs_rsp != '0) cnt++;
        reset = 1'b0;
        for (int k = 0; k < READ_LAT + 3; k++) begin
            step();
            if (obs_rsp != '0) cnt++;
        end
        chk("mf_no_rsp", cnt, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.rd_valid[i] || g_rd[i]) begin
                    bus.rd_valid[i] = ($urandom_range(0, 2) != 0);
                    bus.rd_addr[i]  = 7'($urandom_range(0, 7));
                end
                if (!bus.wr_valid[i] || g_wr[i]) begin
                    bus.wr_valid[i] = ($urandom_range(0, 1) != 0);
                    bus.wr_addr[i]  = 7'($urandom_range(0, 7));
                    bus.wr_data[i]  = rand_line();
                    bus.wr_strb[i]  = 8'($urandom);
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
            g_rd = reset ? '0 : g_rd;
            g_wr = reset ? '0 : g_wr;
        end
        reset = 1'b0;
        idle(READ_LAT + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
